// File: rtl/uart_pkg.sv
// Shared UART types: parity selection and transmitter FSM states.
// Also used by the RX core and the VIP monitor.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    EVEN     = 2'b01,
    ODD      = 2'b10,
    NONE_ALT = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic parity_enabled(input parity_mode_e mode);
    return (mode == EVEN) || (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: loadable down-counter producing a one-cycle tick
// in the last clk cycle of every bit period (period = div + 1 cycles).
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (restart || (r_count == '0)) begin
      r_count <= div;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tick = (r_count == '0);

endmodule

// File: rtl/uart_tx_core.sv
// FIFO-buffered UART transmitter with run-time bit period, parity and stop
// bits. txd and busy are registered copies of the FSM state, one edge behind.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIV_WIDTH-1:0]               baud_div,
  input  logic [1:0]                         parity_mode,
  input  logic                               stop2,
  input  logic                               s_valid,
  input  logic [DATA_BITS-1:0]               s_data,
  output logic                               s_ready,
  output logic                               txd,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [LW-1:0]        w_level;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic [DIV_WIDTH-1:0] w_div;

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_cnt_next;
  logic                 r_stop_cnt;
  logic                 w_stop_cnt_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  parity_mode_e         r_par_mode;
  logic                 r_stop2;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_txd;
  logic                 r_busy;
  logic                 w_txd_next;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign w_level    = LW'(r_wr_ptr - r_rd_ptr);
  assign fifo_level = w_level;
  assign s_ready    = !rst && (w_level < LW'(FIFO_DEPTH));
  assign w_push     = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_data;
  end

  // Word and its parity bit are captured at pop; config inputs only matter then.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift   <= r_mem[r_rd_ptr[AW-1:0]];
      r_par_bit <= (^r_mem[r_rd_ptr[AW-1:0]]) ^ (parity_mode_e'(parity_mode) == ODD);
    end else if ((r_state == DATA) && w_tick) begin
      r_shift <= r_shift >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_mode <= NONE;
      r_stop2    <= 1'b0;
      r_div      <= '0;
    end else if (w_pop) begin
      r_par_mode <= parity_mode_e'(parity_mode);
      r_stop2    <= stop2;
      r_div      <= baud_div;
    end
  end

  // The timer must load the new frame's divisor in the same cycle it is latched.
  assign w_div = w_pop ? baud_div : r_div;

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(w_pop),
    .div    (w_div),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_level != '0) begin
          w_pop           = 1'b1;
          w_state_next    = START;
          w_bit_cnt_next  = '0;
          w_stop_cnt_next = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
            w_state_next    = parity_enabled(r_par_mode) ? PARITY : STOP;
            w_stop_cnt_next = 1'b0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_next    = STOP;
          w_stop_cnt_next = 1'b0;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_cnt_next = 1'b1;
          end else if (w_level != '0) begin
            // Chain straight into the next start bit, no idle gap.
            w_pop           = 1'b1;
            w_state_next    = START;
            w_bit_cnt_next  = '0;
            w_stop_cnt_next = 1'b0;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_txd_next = 1'b1;
    case (r_state)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = r_shift[0];
      PARITY:  w_txd_next = r_par_bit;
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_txd  <= w_txd_next;
      r_busy <= (r_state != IDLE);
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: frames queued at push, decoded off txd
// cycle by cycle and compared against a bench-side waveform model.
module tb_uart_tx_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_level;

  logic        s5_valid;
  logic [4:0]  s5_data;
  logic        s5_ready;
  logic        txd5;
  logic        busy5;
  logic [2:0]  fifo_level5;

  always #5 clk = ~clk;

  uart_tx_core #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .txd(txd), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_core #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut5 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .s_valid(s5_valid), .s_data(s5_data), .s_ready(s5_ready),
    .txd(txd5), .busy(busy5), .fifo_level(fifo_level5)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       s2;
    int         div;
    bit         b2b;
  } frame_t;

  frame_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic int frame_len(input frame_t f);
    return (1 + 8 + (par_on(f.par) ? 1 : 0) + (f.s2 ? 2 : 1)) * (f.div + 1);
  endfunction

  function automatic logic exp_bit(input frame_t f, input int i);
    int b;
    b = i / (f.div + 1);
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if (par_on(f.par) && b == 9) return (^f.data) ^ (f.par == 2'b10);
    return 1'b1;
  endfunction

  // Line monitor
  frame_t     cur;
  bit         mon_active = 1'b0;
  bit         mon_skip = 1'b0;
  int         mon_i, mon_len, mon_b, wave_err, busy_err;
  int         idle_gap = 0;
  int         frames_done = 0;
  int         last_start_cyc = 0;
  int         busy_cycles = 0;
  logic [7:0] mon_data;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
        mon_skip   = 1'b0;
        idle_gap   = 0;
      end else begin
        if (busy) busy_cycles++;
        if (mon_skip) begin
          if (txd) mon_skip = 1'b0;
        end else if (!mon_active) begin
          if (!txd) begin
            if (sb_q.size() == 0) begin
              chk("unexpected_start", sb_q.size(), 1);
              mon_skip = 1'b1;
            end else begin
              cur            = sb_q.pop_front();
              mon_active     = 1'b1;
              mon_i          = 0;
              mon_len        = frame_len(cur);
              wave_err       = 0;
              busy_err       = 0;
              mon_data       = '0;
              last_start_cyc = cyc;
              if (cur.b2b) chk("b2b_gap", idle_gap, 0);
            end
          end else begin
            idle_gap++;
          end
        end
        if (mon_active) begin
          if (txd !== exp_bit(cur, mon_i)) wave_err++;
          if (busy !== 1'b1) busy_err++;
          mon_b = mon_i / (cur.div + 1);
          if (mon_b >= 1 && mon_b <= 8 && (mon_i % (cur.div + 1)) == cur.div / 2)
            mon_data[mon_b-1] = txd;
          mon_i++;
          if (mon_i == mon_len) begin
            chk("frame_wave", wave_err, 0);
            chk("frame_data", mon_data, cur.data);
            chk("frame_busy", busy_err, 0);
            $display("frame %0d: data=%02h par=%0d stop2=%0d div=%0d len=%0d",
                     frames_done, mon_data, cur.par, cur.s2, cur.div, mon_len);
            frames_done++;
            mon_active = 1'b0;
            idle_gap   = 0;
          end
        end
      end
    end
  end

  // Driver
  int push_cyc   = 0;
  int exp_busy   = 0;
  int last_tries = 0;

  task automatic push(input logic [7:0] d, input logic [1:0] p, input logic s2,
                      input int div, input bit b2b);
    frame_t f;
    bit     acc;
    int     tries;
    f.data = d; f.par = p; f.s2 = s2; f.div = div; f.b2b = b2b;
    acc = 1'b0;
    tries = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && tries < 2000) begin
      acc = s_ready;
      @(posedge clk); #1;
      if (!acc) tries++;
    end
    s_valid = 1'b0;
    last_tries = tries;
    chk("push_accept", acc, 1);
    if (acc) begin
      sb_q.push_back(f);
      push_cyc = cyc;
      exp_busy += frame_len(f);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy || mon_active || sb_q.size() != 0 || fifo_level != 0) && n < 5000);
    chk("idle_reached", n < 5000, 1);
    chk("busy_cycles", busy_cycles, exp_busy);
  endtask

  task automatic new_test();
    busy_cycles = 0;
    exp_busy    = 0;
  endtask

  logic [7:0]  tab [6];
  logic [10:0] got_txd5, exp_txd5, got_busy5, exp_busy5;
  logic [4:0]  d5;
  bit          acc5;
  int          done_ref;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    s_valid = 1'b0; s_data = '0; s5_valid = 1'b0; s5_data = '0;
    tab = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A, 8'hC6};

    wait_cycles(3);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_s5_ready", s5_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", s_ready, 1);

    // 8N1 at four cycles per bit
    new_test();
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    push(8'hA5, 2'b00, 1'b0, 3, 1'b0);
    wait_idle();
    chk("a5_latency", last_start_cyc - push_cyc, 2);
    chk("a5_busy_40", busy_cycles, 40);

    // Even then odd parity on the same word
    new_test();
    parity_mode = 2'b01;
    push(8'h07, 2'b01, 1'b0, 3, 1'b0);
    wait_idle();
    chk("even_busy_44", busy_cycles, 44);
    new_test();
    parity_mode = 2'b10;
    push(8'h07, 2'b10, 1'b0, 3, 1'b0);
    wait_idle();
    chk("odd_busy_44", busy_cycles, 44);

    // Six back-to-back pushes into a depth-4 FIFO
    new_test();
    baud_div = 16'd1; parity_mode = 2'b01; stop2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(tab[i], 2'b01, 1'b1, 1, i != 0);
      if (i < 5) chk("no_retry", last_tries, 0);
      if (i == 4) begin
        chk("full_level", fifo_level, 4);
        chk("full_not_ready", s_ready, 0);
      end
    end
    chk("sixth_retried", last_tries > 0, 1);
    chk("refill_level", fifo_level, 4);
    wait_idle();

    // Config change while the first frame is in its data bits
    new_test();
    baud_div = 16'd2; parity_mode = 2'b00; stop2 = 1'b0;
    push(8'h3C, 2'b00, 1'b0, 2, 1'b0);
    push(8'hC3, 2'b10, 1'b1, 4, 1'b1);
    wait_cycles(12);
    baud_div = 16'd4; parity_mode = 2'b10; stop2 = 1'b1;
    wait_idle();

    // Five-bit instance, two stop bits, one cycle per bit
    new_test();
    baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b1;
    d5 = 5'h15;
    s5_valid = 1'b1; s5_data = d5;
    acc5 = s5_ready;
    @(posedge clk); #1;
    s5_valid = 1'b0;
    chk("d5_accept", acc5, 1);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      got_txd5[k]  = txd5;
      got_busy5[k] = busy5;
      if (k == 2) exp_txd5[k] = 1'b0;
      else if (k >= 3 && k <= 7) exp_txd5[k] = d5[k-3];
      else exp_txd5[k] = 1'b1;
      exp_busy5[k] = (k >= 2 && k <= 9);
    end
    chk("d5_txd_seq", got_txd5, exp_txd5);
    chk("d5_busy_seq", got_busy5, exp_busy5);
    $display("dut5 frame: data=%02h txd=%03h busy=%03h", d5, got_txd5, got_busy5);

    // Reset in the middle of a frame with two words queued
    new_test();
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    push(8'h00, 2'b00, 1'b0, 3, 1'b0);
    push(8'h69, 2'b00, 1'b0, 3, 1'b1);
    push(8'h11, 2'b00, 1'b0, 3, 1'b1);
    wait_cycles(10);
    chk("pre_rst_level", fifo_level, 2);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_txd", txd, 0);
    done_ref = frames_done;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("rst_mid_not_ready", s_ready, 0);
    wait_cycles(1);
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_level", fifo_level, 0);
    rst = 1'b0;
    busy_cycles = 0;
    wait_cycles(200);
    chk("post_rst_frames", frames_done - done_ref, 0);
    chk("post_rst_busy", busy_cycles, 0);
    chk("post_rst_txd", txd, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
